// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for fetch-side handshakes.
// Accepts a read request, waits LATENCY cycles, then returns one 32-bit word
// with a single-cycle response pulse. Contents come from a word-addressed
// array written through the program port.
//
// Optional feature macro: IMEM_ERR_CHECK_EN
//   defined   : misaligned or out-of-range reads respond with error=1 and a
//               NOP word; such program writes are dropped.
//   undefined : error tied 0, addr[1:0] ignored, word index wraps.
//
// Parameters:
//   LATENCY      cycles from acceptance to response (1..15)
//   DEPTH_WORDS  array depth in 32-bit words (power of two, >= 2)
// Ports:
//   clk, rst                  clock, async active-high reset
//   instr_read                request strobe
//   instr_mem_address         byte address of requested word
//   instr_mem_resp            single-cycle response pulse
//   instr_mem_rdata           returned word (held until next response)
//   instr_mem_error           read-error flag, valid with instr_mem_resp
//   busy                      high while a request is in WAIT or RESP
//   prog_we/prog_addr/prog_wdata  synchronous array write port
module imem_responder #(
  parameter int unsigned LATENCY     = 3,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_mem_address,
  output logic        instr_mem_resp,
  output logic [31:0] instr_mem_rdata,
  output logic        instr_mem_error,
  output logic        busy,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata
);

  localparam int unsigned IW  = $clog2(DEPTH_WORDS);
  localparam int unsigned CW  = $clog2(LATENCY + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          rd_err;
  logic          wr_ok;

  assign rd_idx = addr_q[IW+1:2];
  assign wr_idx = prog_addr[IW+1:2];

`ifdef IMEM_ERR_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  // Flag misaligned or out-of-range accesses on both ports
  assign rd_err = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= ADDR_LIMIT);
  assign wr_ok  = (prog_addr[1:0] == 2'b00) && ({1'b0, prog_addr} < ADDR_LIMIT);
`else
  logic unused_addr_bits;

  // Byte offset and high address bits are don't-care when wrapping
  assign rd_err = 1'b0;
  assign wr_ok  = 1'b1;
  assign unused_addr_bits = ^{addr_q[31:IW+2], addr_q[1:0],
                              prog_addr[31:IW+2], prog_addr[1:0]};
`endif

  // Program port; array is intentionally not reset
  always_ff @(posedge clk) begin
    if (prog_we && wr_ok) begin
      mem[wr_idx] <= prog_wdata;
    end
  end

  // Request FSM with registered outputs; the array read on the RESP-entry
  // edge sees pre-write contents, giving read-before-write on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      addr_q          <= '0;
      instr_mem_resp  <= 1'b0;
      instr_mem_rdata <= '0;
      instr_mem_error <= 1'b0;
      busy            <= 1'b0;
    end else begin
      instr_mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_read) begin
            addr_q <= instr_mem_address;
            cnt    <= CW'(LATENCY - 1);
            state  <= WAIT;
            busy   <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state           <= RESP;
            instr_mem_resp  <= 1'b1;
            instr_mem_rdata <= rd_err ? NOP : mem[rd_idx];
            instr_mem_error <= rd_err;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          // Back-to-back acceptance keeps busy high
          if (instr_read) begin
            addr_q <= instr_mem_address;
            cnt    <= CW'(LATENCY - 1);
            state  <= WAIT;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
